// File: rtl/tlb_pkg.sv
// Shared types, sizes and the fixed entry pattern for the TLB self-test.
// The pattern helpers serve both the write generator and the checkers.
package tlb_pkg;

    localparam int unsigned TLBNUM = 16;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned VPPN_W = 19;
    localparam int unsigned ASID_W = 10;
    localparam int unsigned PPN_W  = 20;

    typedef struct packed {
        logic              e;
        logic [ASID_W-1:0] asid;
        logic              g;
        logic              ps4m;
        logic [VPPN_W-1:0] vppn;
        logic [PPN_W-1:0]  ppn0;
        logic              v0;
        logic              d0;
        logic [PPN_W-1:0]  ppn1;
        logic              v1;
        logic              d1;
    } tlb_entry_t;

    typedef struct packed {
        logic [VPPN_W-1:0] vppn;
        logic [ASID_W-1:0] asid;
        logic              va12;
    } search_req_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] index;
        logic [PPN_W-1:0] ppn;
        logic             v;
        logic             d;
    } search_rsp_t;

    function automatic logic [VPPN_W-1:0] vppn_of(input logic [IDX_W-1:0] i);
        return {i, 15'h1234};
    endfunction

    function automatic logic [ASID_W-1:0] asid_of(input logic [IDX_W-1:0] i);
        return 10'h100 + {6'd0, i};
    endfunction

    function automatic logic [PPN_W-1:0] ppn0_of(input logic [IDX_W-1:0] i);
        return {i, 16'h0};
    endfunction

    function automatic logic ps4m_of(input logic [IDX_W-1:0] i);
        return (i == 4'd14);
    endfunction

    function automatic tlb_entry_t entry_of(input logic [IDX_W-1:0] i);
        tlb_entry_t t;
        t.e    = (i != 4'd13);
        t.asid = asid_of(i);
        t.g    = (i == 4'd15);
        t.ps4m = ps4m_of(i);
        t.vppn = vppn_of(i);
        t.ppn0 = ppn0_of(i);
        t.v0   = 1'b1;
        t.d0   = i[1];
        t.ppn1 = ppn0_of(i) | 20'h00001;
        t.v1   = ~i[0];
        t.d1   = 1'b1;
        return t;
    endfunction

endpackage

// File: rtl/tlb_if.sv
// TLB access bus: one write port, one read port and two search ports.
interface tlb_if;
    import tlb_pkg::*;

    logic             we;
    logic [IDX_W-1:0] w_index;
    tlb_entry_t       w_entry;
    logic [IDX_W-1:0] r_index;
    tlb_entry_t       r_entry;
    search_req_t      s0_req;
    search_req_t      s1_req;
    search_rsp_t      s0_rsp;
    search_rsp_t      s1_rsp;

    modport master (
        output we, w_index, w_entry, r_index, s0_req, s1_req,
        input  r_entry, s0_rsp, s1_rsp
    );

    modport slave (
        input  we, w_index, w_entry, r_index, s0_req, s1_req,
        output r_entry, s0_rsp, s1_rsp
    );

endinterface

// File: rtl/tlb_core.sv
// 16-entry fully associative TLB: synchronous write, combinational read and
// dual combinational search with lowest-index priority on multiple hits.
module tlb_core (
    input logic  clk,
    input logic  rst,
    tlb_if.slave bus
);
    import tlb_pkg::*;

    tlb_entry_t mem [TLBNUM];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < TLBNUM; i++) mem[i] <= '0;
        end else if (bus.we) begin
            mem[bus.w_index] <= bus.w_entry;
        end
    end

    function automatic search_rsp_t lookup(input tlb_entry_t tab [TLBNUM], input search_req_t q);
        search_rsp_t r;
        logic        hit;
        logic        odd;
        r = '0;
        for (int unsigned i = 0; i < TLBNUM; i++) begin
            hit = tab[i].e && (tab[i].g || tab[i].asid == q.asid) &&
                  (tab[i].ps4m ? (tab[i].vppn[18:9] == q.vppn[18:9]) : (tab[i].vppn == q.vppn));
            if (hit && !r.found) begin
                // 4 MB pages pick the odd half from vppn[8] instead of va12
                odd     = tab[i].ps4m ? q.vppn[8] : q.va12;
                r.found = 1'b1;
                r.index = IDX_W'(i);
                r.ppn   = odd ? tab[i].ppn1 : tab[i].ppn0;
                r.v     = odd ? tab[i].v1   : tab[i].v0;
                r.d     = odd ? tab[i].d1   : tab[i].d0;
            end
        end
        return r;
    endfunction

    assign bus.r_entry = mem[bus.r_index];
    assign bus.s0_rsp  = lookup(mem, bus.s0_req);
    assign bus.s1_rsp  = lookup(mem, bus.s1_req);

endmodule

// File: rtl/tlb_selftest_top.sv
// Stand-alone TLB self-test: writes a fixed pattern, reads it back, then
// runs two search sequences in parallel, reporting sticky status flags.
module tlb_selftest_top #(
    parameter logic SIMULATION = 1'b0,
    parameter logic ERR_INJECT = 1'b0
) (
    input  logic       clk,
    input  logic       resetn,
    output logic       tlb_w_test_ok,
    output logic       tlb_r_test_ok,
    output logic       tlb_s_test_ok,
    output logic       test_error,
    output logic [4:0] tlb_r_cnt,
    output logic [4:0] s0_test_id,
    output logic [4:0] s1_test_id
);
    import tlb_pkg::*;

    localparam logic [2:0] S_WRITE  = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_SEARCH = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    logic [2:0]       state;
    logic [19:0]      pace_cnt;
    logic [IDX_W-1:0] w_cnt;
    logic [IDX_W-1:0] k;
    logic [IDX_W-1:0] j;
    logic             tick;
    logic             r_match;
    logic             s_match;
    logic             odd0;
    tlb_entry_t       w_entry_c;
    search_rsp_t      exp_s0;
    search_rsp_t      exp_s1;

    tlb_if bus ();

    tlb_core u_core (
        .clk (clk),
        .rst (resetn),
        .bus (bus.slave)
    );

    assign tick = SIMULATION ? 1'b1 : (pace_cnt == '1);
    assign k    = s0_test_id[3:0];
    assign j    = 4'd15 - k;

    always_comb begin
        w_entry_c = entry_of(w_cnt);
        if (ERR_INJECT && w_cnt == 4'd5) w_entry_c.ppn0 = w_entry_c.ppn0 ^ 20'h00001;
    end

    assign bus.we      = tick && (state == S_WRITE);
    assign bus.w_index = w_cnt;
    assign bus.w_entry = w_entry_c;
    assign bus.r_index = tlb_r_cnt[3:0];
    assign bus.s0_req  = {vppn_of(k), asid_of(k), k[0]};
    assign bus.s1_req  = {vppn_of(j), 10'h3FF, 1'b1};

    assign r_match = (bus.r_entry == entry_of(tlb_r_cnt[3:0]));

    // Only entry 15 is global, so port 1 hits solely when j == 15
    always_comb begin
        odd0         = ps4m_of(k) ? bus.s0_req.vppn[8] : bus.s0_req.va12;
        exp_s0.found = (k != 4'd13);
        exp_s0.index = k;
        exp_s0.ppn   = ppn0_of(k) | {19'd0, odd0};
        exp_s0.v     = odd0 ? ~k[0] : 1'b1;
        exp_s0.d     = odd0 ? 1'b1  : k[1];
        exp_s1.found = (j == 4'd15);
        exp_s1.index = 4'd15;
        exp_s1.ppn   = ppn0_of(4'd15) | 20'h00001;
        exp_s1.v     = 1'b0;
        exp_s1.d     = 1'b1;
        s_match = (bus.s0_rsp.found == exp_s0.found) && (!exp_s0.found || bus.s0_rsp == exp_s0) &&
                  (bus.s1_rsp.found == exp_s1.found) && (!exp_s1.found || bus.s1_rsp == exp_s1);
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state         <= S_WRITE;
            pace_cnt      <= '0;
            w_cnt         <= '0;
            tlb_w_test_ok <= 1'b0;
            tlb_r_test_ok <= 1'b0;
            tlb_s_test_ok <= 1'b0;
            test_error    <= 1'b0;
            tlb_r_cnt     <= '0;
            s0_test_id    <= '0;
            s1_test_id    <= '0;
        end else begin
            pace_cnt <= pace_cnt + 20'd1;
            if (tick) begin
                case (state)
                    S_WRITE: begin
                        w_cnt <= w_cnt + 4'd1;
                        if (w_cnt == 4'd15) begin
                            tlb_w_test_ok <= 1'b1;
                            state         <= S_READ;
                        end
                    end
                    S_READ: begin
                        if (!r_match) begin
                            test_error <= 1'b1;
                            state      <= S_HALT;
                        end else begin
                            tlb_r_cnt <= tlb_r_cnt + 5'd1;
                            if (tlb_r_cnt == 5'd15) begin
                                tlb_r_test_ok <= 1'b1;
                                state         <= S_SEARCH;
                            end
                        end
                    end
                    S_SEARCH: begin
                        if (!s_match) begin
                            test_error <= 1'b1;
                            state      <= S_HALT;
                        end else begin
                            s0_test_id <= s0_test_id + 5'd1;
                            s1_test_id <= s1_test_id + 5'd1;
                            if (s0_test_id == 5'd15) begin
                                tlb_s_test_ok <= 1'b1;
                                state         <= S_DONE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tlb_selftest_top.sv
// Directed bench for tlb_selftest_top: normal run, injected error, slow pacing,
// mid-run reset, plus direct probes of the tlb_core search/read ports.
module tb_tlb_selftest_top;
    import tlb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, rst_err = 1'b1, rst_slow = 1'b1, rst_core = 1'b1;

    logic       w_ok, r_ok, s_ok, err;
    logic [4:0] r_cnt, s0_id, s1_id;
    logic       ew_ok, er_ok, es_ok, eerr;
    logic [4:0] er_cnt, es0_id, es1_id;
    logic       sw_ok, sr_ok, ss_ok, serr;
    logic [4:0] sr_cnt, ss0_id, ss1_id;

    int checks = 0;
    int errors = 0;

    tlb_selftest_top #(.SIMULATION(1'b1), .ERR_INJECT(1'b0)) dut (
        .clk(clk), .resetn(rst), .tlb_w_test_ok(w_ok), .tlb_r_test_ok(r_ok),
        .tlb_s_test_ok(s_ok), .test_error(err), .tlb_r_cnt(r_cnt),
        .s0_test_id(s0_id), .s1_test_id(s1_id));

    tlb_selftest_top #(.SIMULATION(1'b1), .ERR_INJECT(1'b1)) dut_err (
        .clk(clk), .resetn(rst_err), .tlb_w_test_ok(ew_ok), .tlb_r_test_ok(er_ok),
        .tlb_s_test_ok(es_ok), .test_error(eerr), .tlb_r_cnt(er_cnt),
        .s0_test_id(es0_id), .s1_test_id(es1_id));

    tlb_selftest_top #(.SIMULATION(1'b0), .ERR_INJECT(1'b0)) dut_slow (
        .clk(clk), .resetn(rst_slow), .tlb_w_test_ok(sw_ok), .tlb_r_test_ok(sr_ok),
        .tlb_s_test_ok(ss_ok), .test_error(serr), .tlb_r_cnt(sr_cnt),
        .s0_test_id(ss0_id), .s1_test_id(ss1_id));

    tlb_if tb_bus ();

    tlb_core u_core (.clk(clk), .rst(rst_core), .bus(tb_bus.slave));

    task automatic test_reset;
        #1000;
        checks++;
        if ({w_ok, r_ok, s_ok, err, r_cnt, s0_id, s1_id} !== 19'd0) begin
            errors++;
            $display("FAIL reset_main: got %h expected 0", {w_ok, r_ok, s_ok, err, r_cnt, s0_id, s1_id});
        end
        checks++;
        if ({ew_ok, er_ok, es_ok, eerr, er_cnt, es0_id, es1_id} !== 19'd0) begin
            errors++;
            $display("FAIL reset_err: got %h expected 0", {ew_ok, er_ok, es_ok, eerr, er_cnt, es0_id, es1_id});
        end
        checks++;
        if ({sw_ok, sr_ok, ss_ok, serr, sr_cnt, ss0_id, ss1_id} !== 19'd0) begin
            errors++;
            $display("FAIL reset_slow: got %h expected 0", {sw_ok, sr_ok, ss_ok, serr, sr_cnt, ss0_id, ss1_id});
        end
        tb_bus.r_index = 4'd0;
        #1;
        checks++;
        if (tb_bus.r_entry !== tlb_entry_t'('0)) begin
            errors++;
            $display("FAIL reset_core_entry: got %h expected 0", tb_bus.r_entry);
        end
    endtask

    task automatic run_and_check(input string tag);
        int t_w, t_r, t_s;
        t_w = 0; t_r = 0; t_s = 0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            if (w_ok && t_w == 0) t_w = c;
            if (r_ok && t_r == 0) t_r = c;
            if (s_ok && t_s == 0) t_s = c;
            if (c == 20) begin
                checks++;
                if (r_cnt !== 5'd4) begin
                    errors++;
                    $display("FAIL %s_rcnt_mid: got %0d expected 4", tag, r_cnt);
                end
            end
        end
        checks++;
        if (t_w !== 16) begin errors++; $display("FAIL %s_w_ok_cycle: got %0d expected 16", tag, t_w); end
        checks++;
        if (t_r !== 32) begin errors++; $display("FAIL %s_r_ok_cycle: got %0d expected 32", tag, t_r); end
        checks++;
        if (t_s !== 48) begin errors++; $display("FAIL %s_s_ok_cycle: got %0d expected 48", tag, t_s); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL %s_error: got %b expected 0", tag, err); end
        checks++;
        if ({r_cnt, s0_id, s1_id} !== {5'd16, 5'd16, 5'd16}) begin
            errors++;
            $display("FAIL %s_counters: got %0d/%0d/%0d expected 16/16/16", tag, r_cnt, s0_id, s1_id);
        end
    endtask

    task automatic test_full_run;
        run_and_check("full");
    endtask

    task automatic test_err_inject;
        checks++;
        if ({ew_ok, eerr, er_ok, es_ok} !== 4'b1100) begin
            errors++;
            $display("FAIL err_flags: got w/e/r/s=%b expected 1100", {ew_ok, eerr, er_ok, es_ok});
        end
        checks++;
        if (er_cnt !== 5'd5) begin errors++; $display("FAIL err_rcnt: got %0d expected 5", er_cnt); end
        checks++;
        if (es0_id !== 5'd0) begin errors++; $display("FAIL err_s0id: got %0d expected 0", es0_id); end
    endtask

    task automatic core_write(input logic [3:0] idx, input tlb_entry_t ent);
        @(negedge clk);
        tb_bus.we = 1'b1; tb_bus.w_index = idx; tb_bus.w_entry = ent;
        @(negedge clk);
        tb_bus.we = 1'b0;
    endtask

    task automatic probe(input string name, input logic port, input search_req_t q,
                         input logic exp_found, input logic [3:0] exp_idx,
                         input logic [19:0] exp_ppn, input logic exp_v, input logic exp_d);
        search_rsp_t r;
        if (port) tb_bus.s1_req = q; else tb_bus.s0_req = q;
        #1;
        r = port ? tb_bus.s1_rsp : tb_bus.s0_rsp;
        checks++;
        if (r.found !== exp_found || (exp_found && {r.index, r.ppn, r.v, r.d} !== {exp_idx, exp_ppn, exp_v, exp_d})) begin
            errors++;
            $display("FAIL %s: got f=%b i=%0d ppn=%h v=%b d=%b expected f=%b i=%0d ppn=%h v=%b d=%b",
                     name, r.found, r.index, r.ppn, r.v, r.d, exp_found, exp_idx, exp_ppn, exp_v, exp_d);
        end
    endtask

    task automatic test_core_probe;
        tlb_entry_t e13, e14, e15;
        e13 = '{e:1'b0, asid:10'h10D, g:1'b0, ps4m:1'b0, vppn:{4'hD, 15'h1234},
                ppn0:20'hD0000, v0:1'b1, d0:1'b0, ppn1:20'hD0001, v1:1'b0, d1:1'b1};
        e14 = '{e:1'b1, asid:10'h10E, g:1'b0, ps4m:1'b1, vppn:{4'hE, 15'h1234},
                ppn0:20'hE0000, v0:1'b1, d0:1'b1, ppn1:20'hE0001, v1:1'b1, d1:1'b1};
        e15 = '{e:1'b1, asid:10'h10F, g:1'b1, ps4m:1'b0, vppn:{4'hF, 15'h1234},
                ppn0:20'hF0000, v0:1'b1, d0:1'b1, ppn1:20'hF0001, v1:1'b0, d1:1'b1};
        @(negedge clk); rst_core = 1'b0;
        core_write(4'd13, e13);
        core_write(4'd14, e14);
        core_write(4'd15, e15);
        probe("s0_k13_disabled", 1'b0, '{vppn:{4'hD, 15'h1234}, asid:10'h10D, va12:1'b1}, 1'b0, 4'd0, 20'h0, 1'b0, 1'b0);
        probe("s0_k14_4m_even", 1'b0, '{vppn:{4'hE, 15'h1234}, asid:10'h10E, va12:1'b0}, 1'b1, 4'd14, 20'hE0000, 1'b1, 1'b1);
        probe("s0_4m_odd_vppn8", 1'b0, '{vppn:{4'hE, 15'h1334}, asid:10'h10E, va12:1'b0}, 1'b1, 4'd14, 20'hE0001, 1'b1, 1'b1);
        probe("s1_k0_global", 1'b1, '{vppn:{4'hF, 15'h1234}, asid:10'h3FF, va12:1'b1}, 1'b1, 4'd15, 20'hF0001, 1'b0, 1'b1);
        probe("s1_k1_asid_miss", 1'b1, '{vppn:{4'hE, 15'h1234}, asid:10'h3FF, va12:1'b1}, 1'b0, 4'd0, 20'h0, 1'b0, 1'b0);
        probe("s0_wrong_asid", 1'b0, '{vppn:{4'hE, 15'h1234}, asid:10'h10F, va12:1'b0}, 1'b0, 4'd0, 20'h0, 1'b0, 1'b0);
        tb_bus.r_index = 4'd14;
        #1;
        checks++;
        if (tb_bus.r_entry !== e14) begin
            errors++;
            $display("FAIL core_read14: got %h expected %h", tb_bus.r_entry, e14);
        end
        core_write(4'd3, e15);
        probe("s1_dup_lowest", 1'b1, '{vppn:{4'hF, 15'h1234}, asid:10'h3FF, va12:1'b0}, 1'b1, 4'd3, 20'hF0000, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_read;
        logic seen;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (r_cnt == 5'd7) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL midread_reach7: got %0d expected 7", r_cnt); end
        rst = 1'b1;
        #1;
        checks++;
        if ({w_ok, r_ok, s_ok, err, r_cnt, s0_id, s1_id} !== 19'd0) begin
            errors++;
            $display("FAIL midread_reset: got %h expected 0", {w_ok, r_ok, s_ok, err, r_cnt, s0_id, s1_id});
        end
        @(negedge clk); rst = 1'b0;
        run_and_check("rerun");
    endtask

    task automatic test_slow_pacing;
        checks++;
        if ({sw_ok, sr_ok, ss_ok, serr, sr_cnt, ss0_id, ss1_id} !== 19'd0) begin
            errors++;
            $display("FAIL slow_idle: got %h expected 0", {sw_ok, sr_ok, ss_ok, serr, sr_cnt, ss0_id, ss1_id});
        end
    endtask

    initial begin
        tb_bus.we = 1'b0; tb_bus.w_index = '0; tb_bus.w_entry = '0; tb_bus.r_index = '0;
        tb_bus.s0_req = '0; tb_bus.s1_req = '0;
        test_reset();
        #999;
        rst = 1'b0; rst_err = 1'b0; rst_slow = 1'b0;
        test_full_run();
        test_err_inject();
        test_core_probe();
        test_reset_mid_read();
        test_slow_pacing();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
